// File: rtl/spi_coord_rx.sv
// SPI slave receiver for one complex coordinate per frame.
// Frame = 2*WIDTH bits, MSB first: real word, then imaginary word.
// The SPI pins are synchronised into clk. Completed pairs are offered on a valid/ready port.
module spi_coord_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_clk,
    input  logic             spi_en,
    input  logic             spi_data,
    output logic [WIDTH-1:0] coord_real,
    output logic [WIDTH-1:0] coord_imag,
    output logic             coord_valid,
    input  logic             coord_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int FRAME = 2 * WIDTH;
    localparam int CW    = $clog2(FRAME + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, en_sync, data_sync;
    logic                   clk_d, en_d;
    logic [SYNC_STAGES:0]   prime;
    logic                   armed;
    state_t                 state;
    logic [CW-1:0]          cnt;
    // The oldest bit is dropped when the final bit arrives, so only FRAME-1 bits need storage.
    // shift_next holds the full frame value.
    logic [FRAME-2:0]       shreg;
    logic [FRAME-1:0]       shift_next;

    logic clk_s, en_s, data_s, clk_rise, en_rise, en_fall;

    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign en_s       = en_sync[SYNC_STAGES-1];
    assign data_s     = data_sync[SYNC_STAGES-1];
    assign clk_rise   = clk_s & ~clk_d;
    assign en_rise    = en_s & ~en_d;
    assign en_fall    = ~en_s & en_d;
    assign shift_next = {shreg, data_s};

    // Synchronisers, edge-detect flops and the post-reset arming logic.
    // A frame already in progress when rst falls must not be picked up half way through.
    // The arming flag is therefore set only after the chains have refilled and spi_en has been seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '0;
            en_sync   <= '0;
            data_sync <= '0;
            clk_d     <= 1'b0;
            en_d      <= 1'b0;
            prime     <= '0;
            armed     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], spi_en};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            clk_d     <= clk_s;
            en_d      <= en_s;
            prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
            armed     <= armed | (prime[SYNC_STAGES] & ~en_s);
        end
    end

    // Frame FSM: deserialise, commit or flag overrun, and run the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            coord_real  <= '0;
            coord_imag  <= '0;
            coord_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (coord_valid && coord_ready)
                coord_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en_rise && armed) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (clk_rise) begin
                        shreg <= shift_next[FRAME-2:0];
                        cnt   <= cnt + CW'(1);
                        if (cnt == CW'(FRAME - 1)) begin
                            state <= WAIT_END;
                            // A pair that is being accepted on this edge frees the slot for the new one.
                            if (!coord_valid || coord_ready) begin
                                coord_real  <= shift_next[FRAME-1:WIDTH];
                                coord_imag  <= shift_next[WIDTH-1:0];
                                coord_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else if (en_fall) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                WAIT_END: begin
                    if (en_fall) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_coord_rx.sv
// Bench for spi_coord_rx. Directed frames are sent, and a scoreboard queue holds the pairs the DUT should present.
module tb_spi_coord_rx;

    logic        clk, rst, spi_clk, spi_en, spi_data, coord_ready;
    logic [31:0] coord_real, coord_imag;
    logic        coord_valid, frame_err, overrun, busy;

    spi_coord_rx #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_en(spi_en), .spi_data(spi_data),
        .coord_real(coord_real), .coord_imag(coord_imag), .coord_valid(coord_valid),
        .coord_ready(coord_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    int          err_cnt = 0, ovr_cnt = 0, err_run = 0, ovr_run = 0;
    logic [63:0] exp_q[$];
    logic        seen = 1'b0;
    time         last_rise_t = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard each time a new pair is presented, and tracks pulse counts and widths.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (coord_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", {coord_real, coord_imag});
                end else begin
                    e = exp_q.pop_front();
                    chk("coord_pair", {coord_real, coord_imag}, e);
                    chk("valid_latency", 64'(($time - last_rise_t) <= 350), 64'd1);
                end
            end
            if (coord_valid && coord_ready) seen = 1'b0;
        end
        if (frame_err) begin
            if (err_run == 0) err_cnt++;
            err_run++;
        end else begin
            if (err_run != 0) chk("frame_err_width", 64'(err_run), 64'd1);
            err_run = 0;
        end
        if (overrun) begin
            if (ovr_run == 0) ovr_cnt++;
            ovr_run++;
        end else begin
            if (ovr_run != 0) chk("overrun_width", 64'(ovr_run), 64'd1);
            ovr_run = 0;
        end
    end

    // Clock bits v[63-from] .. v[64-to] MSB first.
    // With acc set, coord_ready is raised for exactly the edge that commits the final bit.
    task automatic shift_bits(input logic [63:0] v, input int from, input int to, input bit acc);
        for (int i = from; i < to; i++) begin
            spi_data = v[63-i];
            #250 spi_clk = 1'b1;
            last_rise_t = $time;
            if (acc && i == to - 1) begin
                @(posedge clk);
                @(posedge clk);
                #1 coord_ready = 1'b1;
                @(posedge clk);
                #1 coord_ready = 1'b0;
                #100;
            end else begin
                #250;
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [63:0] v, input int nbits, input bit acc);
        spi_en = 1'b1;
        #300;
        shift_bits(v, 0, nbits, acc);
        #300 spi_en = 1'b0;
        #1000;
    endtask

    task automatic accept_pulse();
        @(negedge clk);
        coord_ready = 1'b1;
        @(posedge clk);
        #1 coord_ready = 1'b0;
        chk("valid_clear_after_accept", 64'(coord_valid), 64'd0);
    endtask

    localparam logic [63:0] F_ZERO = 64'h00000000_00000000;
    localparam logic [63:0] F_FIX  = 64'hF0000000_08000000;
    localparam logic [63:0] F_SHRT = 64'hDEADBEEF_12345678;
    localparam logic [63:0] F_ONE  = 64'h10000000_00000000;
    localparam logic [63:0] F_A    = 64'h10000000_10000000;
    localparam logic [63:0] F_B    = 64'h20000000_20000000;
    localparam logic [63:0] F_C    = 64'h40000000_C0000000;
    localparam logic [63:0] F_D    = 64'h30000000_A5A5A5A5;

    initial begin
        int e0, o0;
        rst = 1'b1; spi_clk = 1'b0; spi_en = 1'b0; spi_data = 1'b0; coord_ready = 1'b0;
        #20;
        chk("reset_outputs", {coord_real, coord_imag, coord_valid, frame_err, overrun, busy}, 64'd0);
        #293 rst = 1'b0;
        #1000;

        // 1: zero frame, held until accepted
        exp_q.push_back(F_ZERO);
        send_frame(F_ZERO, 64, 1'b0);
        chk("zero_valid_held", 64'(coord_valid), 64'd1);
        chk("zero_data", {coord_real, coord_imag}, F_ZERO);
        accept_pulse();

        // 2: fixed-point values
        e0 = err_cnt; o0 = ovr_cnt;
        exp_q.push_back(F_FIX);
        send_frame(F_FIX, 64, 1'b0);
        chk("fix_data", {coord_real, coord_imag}, F_FIX);
        chk("fix_no_flags", 64'((err_cnt - e0) + (ovr_cnt - o0)), 64'd0);
        chk("fix_busy_idle", 64'(busy), 64'd0);
        accept_pulse();

        // 3: short frame, then a good frame
        e0 = err_cnt;
        send_frame(F_SHRT, 40, 1'b0);
        chk("short_frame_err", 64'(err_cnt - e0), 64'd1);
        chk("short_no_valid", 64'(coord_valid), 64'd0);
        exp_q.push_back(F_ONE);
        send_frame(F_ONE, 64, 1'b0);
        chk("after_short_data", {coord_real, coord_imag}, F_ONE);
        accept_pulse();

        // 4: overrun keeps the first pair
        o0 = ovr_cnt;
        exp_q.push_back(F_A);
        send_frame(F_A, 64, 1'b0);
        send_frame(F_B, 64, 1'b0);
        chk("overrun_pulse", 64'(ovr_cnt - o0), 64'd1);
        chk("overrun_hold_data", {coord_real, coord_imag}, F_A);
        chk("overrun_valid", 64'(coord_valid), 64'd1);

        // 5: accept on the commit edge of the next frame
        o0 = ovr_cnt;
        exp_q.push_back(F_C);
        send_frame(F_C, 64, 1'b1);
        chk("accept_commit_data", {coord_real, coord_imag}, F_C);
        chk("accept_commit_valid", 64'(coord_valid), 64'd1);
        chk("accept_commit_no_ovr", 64'(ovr_cnt - o0), 64'd0);
        accept_pulse();

        // 6: reset mid-frame
        e0 = err_cnt;
        spi_en = 1'b1;
        #300;
        shift_bits(F_B, 0, 20, 1'b0);
        #100 rst = 1'b1;
        #1;
        chk("midreset_outputs", {coord_real, coord_imag, coord_valid, frame_err, overrun, busy}, 64'd0);
        #199 rst = 1'b0;
        shift_bits(F_B, 20, 64, 1'b0);
        #300 spi_en = 1'b0;
        #1000;
        chk("midreset_no_valid", 64'(coord_valid), 64'd0);
        chk("midreset_no_err", 64'(err_cnt - e0), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        exp_q.push_back(F_D);
        send_frame(F_D, 64, 1'b0);
        chk("fresh_frame_data", {coord_real, coord_imag}, F_D);
        accept_pulse();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_coord_rx.md
# spi_coord_rx

SPI slave receiver that accepts one complex-plane coordinate per frame from an external SPI master. Each frame carries two signed Q4.28 words, real then imaginary, MSB first. The block synchronises the SPI pins into the `clk` domain, deserialises the frame, and presents the pair to the Mandelbrot iteration core over a valid/ready handshake. It also flags short frames and dropped frames.

## Interface

Parameters:
- `WIDTH`, default 32: bits per coordinate word (signed Q4.28 at 32).
- `SYNC_STAGES`, default 2: synchroniser flops on each SPI input, minimum 2.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_clk`  in  1  SPI clock from master, asynchronous to `clk`, idle low.
- `spi_en`  in  1  frame enable, active-high, asynchronous.
- `spi_data`  in  1  serial data; master changes it on `spi_clk` fall, block samples it on rise.
- `coord_real`  out  WIDTH  real coordinate of the last accepted frame.
- `coord_imag`  out  WIDTH  imaginary coordinate of the last accepted frame.
- `coord_valid`  out  1  coordinate pair available.
- `coord_ready`  in  1  consumer accepts the pair.
- `frame_err`  out  1  one-cycle pulse: `spi_en` fell before 2·WIDTH bits.
- `overrun`  out  1  one-cycle pulse: a complete frame was dropped because `coord_valid` was still high.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

- **Synchronisers.** `spi_clk`, `spi_en` and `spi_data` each pass through SYNC_STAGES flops. Then:
  - rise of synced `spi_clk` = one extra flop plus compare;
  - rise and fall of synced `spi_en` are detected the same way;
  - data is sampled from the synced `spi_data` in the same cycle the `spi_clk` rise is detected.
- **Shift register and counter.** 2·WIDTH-bit shift register, left shift, new bit enters at the LSB. Bit counter runs 0..2·WIDTH.
  - Upper WIDTH bits become `coord_real`; lower WIDTH bits become `coord_imag`.
- **State machine:**
  - IDLE: counter cleared. A synced `spi_en` rise goes to SHIFT. `spi_clk` edges are ignored.
  - SHIFT: each detected `spi_clk` rise shifts in one bit and increments the counter.
    - When the 2·WIDTH-th bit is shifted, commit the frame (below) and go to WAIT_END.
    - A synced `spi_en` fall with counter < 2·WIDTH pulses `frame_err`, returns to IDLE, and leaves the outputs unchanged.
  - WAIT_END: further `spi_clk` rises are ignored with no flag. A synced `spi_en` fall returns to IDLE.
- **Commit:**
  - If `coord_valid` is 0, or `coord_valid & coord_ready` in the same cycle: load `coord_real` and `coord_imag` from the completed shift value (including the final bit), and `coord_valid` becomes or stays 1.
  - Otherwise: keep the old pair, keep `coord_valid` high, and pulse `overrun`.
- **Handshake.**
  - `coord_valid` holds, with the data stable, until a clk edge where `coord_valid & coord_ready`; it clears on that edge unless a commit occurs on the same edge.
  - `coord_ready` while `coord_valid` is 0 has no effect.
- **Arithmetic.** None; words pass bit-exact. Sign interpretation (two's complement, scale 2^28) belongs to the consumer.

## Timing

- **Reset.** Asynchronous. While `rst` is high:
  - all synchroniser flops, shift register and counter are 0; state is IDLE;
  - `coord_real`, `coord_imag`, `coord_valid`, `frame_err`, `overrun` and `busy` are all 0.
- **Reset mid-frame.** The frame is abandoned and no `frame_err` is generated. After `rst` falls, a frame already in progress (`spi_en` already high) is ignored until `spi_en` goes low and then high again.
- **Input constraints.**
  - Each `spi_clk` level must be held for at least 1 `clk` period plus setup. The standard configuration is `clk` 100 ns and `spi_clk` 250 ns (≥1.25 clk periods per level).
  - `spi_en` must lead the first `spi_clk` rise and trail the last fall by at least 2 `clk` periods.
- **Bit latency.** A `spi_clk` pin rise that is captured at clk edge k is shifted in at edge k+SYNC_STAGES. With the default, that is edge k+2.
- **Output latency.** `coord_valid` rises at the same edge that shifts the final bit, i.e. SYNC_STAGES+1 `clk` edges worst case after the final `spi_clk` pin rise.
- **Pulse width.** `frame_err` and `overrun` are exactly one `clk` cycle each.
- **Busy.** `busy` rises one edge after the synced `spi_en` rise is detected and falls one edge after the synced fall is detected.

## Test plan

1. **Zero frame.** Send real 0x00000000, imag 0x00000000 with `coord_ready` low.
   - `coord_valid` = 1 within 3 clk of the last `spi_clk` rise; both words are 0; it stays high until `coord_ready` is pulsed, then 0 on the next edge.
2. **Fixed-point values.** Send −1.0 and +0.5, i.e. 0xF0000000 and 0x08000000.
   - `coord_real` = 0xF0000000, `coord_imag` = 0x08000000; no `frame_err`/`overrun`.
3. **Short frame.** Send 40 bits, then drop `spi_en`.
   - One `frame_err` pulse; `coord_valid` stays 0.
   - A following full frame (0x10000000, 0x00000000) is received correctly.
4. **Overrun.** Send 0x10000000/0x10000000, then 0x20000000/0x20000000, with `coord_ready` held low.
   - One `overrun` pulse; the outputs still hold 0x10000000 / 0x10000000.
5. **Simultaneous accept and commit.** Hold `coord_ready` high on the exact commit edge of a second frame.
   - `coord_valid` stays 1 with the second frame's data; no `overrun`.
6. **Reset mid-frame.** Assert `rst` after 20 bits.
   - All outputs are 0 immediately.
   - The remaining bits of that frame produce nothing.
   - A fresh frame after `spi_en` toggles is received correctly.
